// File: rtl/iob_bus_arbiter2_pkg.sv
// Shared definitions for the two-master IOb arbiter: the owner/grant encoding and the
// bit layout of the IOb request {avalid, addr, wdata, wstrb} and response {rdata, rvalid, ready}.
package iob_bus_arbiter2_pkg;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } gnt_t;

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 2;
    endfunction

    // Request field offsets, counted from the LSB.
    function automatic int wstrb_lsb();
        return 0;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w / 8 + data_w;
    endfunction

    function automatic int avalid_bit(input int addr_w, input int data_w);
        return data_w / 8 + data_w + addr_w;
    endfunction

    // Response field offsets.
    localparam int READY_BIT  = 0;
    localparam int RVALID_BIT = 1;
    localparam int RDATA_LSB  = 2;

endpackage

// File: rtl/iob_bus_arbiter2_gnt.sv
// iob_arb_gnt: combinational grant for the two-master arbiter.
// Contention policy: fixed m1 priority, or alternating when IOB_ARB_ROUND_ROBIN_EN is defined.
module iob_arb_gnt
    import iob_bus_arbiter2_pkg::*;
(
    input  logic [1:0] i_avalid,
    input  gnt_t       i_owner,
    input  logic       i_rd_cnt_zero,
    output gnt_t       o_gnt
);

    always_comb begin
        o_gnt = i_owner;
        // With reads in flight the owner keeps the bus so responses stay in order.
        if (i_rd_cnt_zero) begin
            case (i_avalid)
                2'b01:   o_gnt = GNT_M0;
                2'b10:   o_gnt = GNT_M1;
`ifdef IOB_ARB_ROUND_ROBIN_EN
                2'b11:   o_gnt = (i_owner == GNT_M1) ? GNT_M0 : GNT_M1;
`else
                2'b11:   o_gnt = GNT_M1;
`endif
                default: o_gnt = i_owner;
            endcase
        end
    end

endmodule

// File: rtl/iob_bus_arbiter2.sv
// Two-master (m0 = instruction, m1 = data) to one-slave IOb arbiter with outstanding-read
// tracking and response routing. Optional alternating contention policy: IOB_ARB_ROUND_ROBIN_EN.
module iob_bus_arbiter2
    import iob_bus_arbiter2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_RD = 4
) (
    input  logic                                clk_i,
    input  logic                                arst_i,
    input  logic                                cke_i,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]    m0_req_i,
    output logic [resp_w(DATA_W)-1:0]           m0_resp_o,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]    m1_req_i,
    output logic [resp_w(DATA_W)-1:0]           m1_resp_o,
    output logic [req_w(ADDR_W, DATA_W)-1:0]    s_req_o,
    input  logic [resp_w(DATA_W)-1:0]           s_resp_i,
    output logic                                err_o
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_RD + 1);
    localparam int AV_BIT = avalid_bit(ADDR_W, DATA_W);
    localparam int WS_LSB = wstrb_lsb();

    gnt_t             r_owner;
    gnt_t             w_owner_next;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] w_rd_cnt_next;
    logic             r_err;
    logic             w_err_next;

    gnt_t             w_gnt;
    logic [REQ_W-1:0] w_gnt_req;
    logic             w_rd_cnt_zero;
    logic             w_stall;
    logic             w_s_avalid;
    logic             w_s_ready;
    logic             w_s_rvalid;
    logic [DATA_W-1:0] w_s_rdata;
    logic             w_port_ready;
    logic             w_accept;
    logic             w_rd_accept;
    logic             w_rsp_ok;
    logic             w_rsp_bad;

    iob_arb_gnt u_gnt (
        .i_avalid      ({m1_req_i[AV_BIT], m0_req_i[AV_BIT]}),
        .i_owner       (r_owner),
        .i_rd_cnt_zero (w_rd_cnt_zero),
        .o_gnt         (w_gnt)
    );

    assign w_rd_cnt_zero = (r_rd_cnt == '0);
    assign w_stall       = (r_rd_cnt == CNT_W'(MAX_RD));
    assign w_gnt_req     = (w_gnt == GNT_M1) ? m1_req_i : m0_req_i;

    assign w_s_ready  = s_resp_i[READY_BIT];
    assign w_s_rvalid = s_resp_i[RVALID_BIT];
    assign w_s_rdata  = s_resp_i[RDATA_LSB +: DATA_W];

    // Handshake outputs are forced low while reset is held, not only after the first edge.
    assign w_s_avalid   = w_gnt_req[AV_BIT] & ~w_stall & ~arst_i;
    assign w_port_ready = w_s_ready & ~w_stall & ~arst_i;

    assign w_accept    = w_s_avalid & w_s_ready;
    assign w_rd_accept = w_accept & (w_gnt_req[WS_LSB +: STRB_W] == '0);
    assign w_rsp_ok    = w_s_rvalid & ~w_rd_cnt_zero;
    assign w_rsp_bad   = w_s_rvalid & w_rd_cnt_zero;

    assign s_req_o = {w_s_avalid, w_gnt_req[REQ_W-2:0]};

    assign m0_resp_o = {w_s_rdata,
                        w_rsp_ok & (r_owner == GNT_M0),
                        w_port_ready & (w_gnt == GNT_M0)};
    assign m1_resp_o = {w_s_rdata,
                        w_rsp_ok & (r_owner == GNT_M1),
                        w_port_ready & (w_gnt == GNT_M1)};

    assign err_o = r_err;

    always_comb begin
        w_owner_next  = r_owner;
        w_rd_cnt_next = r_rd_cnt;
        w_err_next    = r_err | w_rsp_bad;
        if (w_accept) begin
            w_owner_next = w_gnt;
        end
        // A read issued and a read answered in the same cycle cancel out.
        case ({w_rd_accept, w_rsp_ok})
            2'b10:   w_rd_cnt_next = r_rd_cnt + CNT_W'(1);
            2'b01:   w_rd_cnt_next = r_rd_cnt - CNT_W'(1);
            default: w_rd_cnt_next = r_rd_cnt;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_owner  <= GNT_M0;
            r_rd_cnt <= '0;
            r_err    <= 1'b0;
        end else if (cke_i) begin
            r_owner  <= w_owner_next;
            r_rd_cnt <= w_rd_cnt_next;
            r_err    <= w_err_next;
        end
    end

endmodule

// File: tb/tb_iob_bus_arbiter2.sv
// Directed bench for iob_bus_arbiter2 (default parameters, MAX_RD=4); contention
// expectations follow IOB_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_iob_bus_arbiter2;

    logic        clk = 1'b0;
    logic        arst;
    logic        cke;
    logic [68:0] m0_req;
    logic [68:0] m1_req;
    logic [68:0] s_req;
    logic [33:0] m0_resp;
    logic [33:0] m1_resp;
    logic [33:0] s_resp;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iob_bus_arbiter2 #(
        .ADDR_W (32),
        .DATA_W (32),
        .MAX_RD (4)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .cke_i     (cke),
        .m0_req_i  (m0_req),
        .m0_resp_o (m0_resp),
        .m1_req_i  (m1_req),
        .m1_resp_o (m1_resp),
        .s_req_o   (s_req),
        .s_resp_i  (s_resp),
        .err_o     (err)
    );

    function automatic logic [68:0] mk_req(input logic av, input logic [31:0] addr, input logic [3:0] wstrb);
        return {av, addr, 32'h1234_5678, wstrb};
    endfunction

    function automatic logic [33:0] mk_rsp(input logic rdy, input logic rv, input logic [31:0] rdata);
        return {rdata, rv, rdy};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_addr;

        // Reset with live requests and a stray rvalid: nothing may leak out.
        arst   = 1'b1;
        cke    = 1'b1;
        m0_req = mk_req(1'b1, 32'h100, 4'h0);
        m1_req = mk_req(1'b1, 32'h104, 4'h0);
        s_resp = mk_rsp(1'b1, 1'b1, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_s_avalid", s_req[68], 1'b0);
        check_val("rst_m0_ready", m0_resp[0], 1'b0);
        check_val("rst_m1_ready", m1_resp[0], 1'b0);
        check_val("rst_m0_rvalid", m0_resp[1], 1'b0);
        check_val("rst_err", err, 1'b0);
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        m1_req = mk_req(1'b0, 32'h0, 4'h0);
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        arst   = 1'b0;
        tick();

        // Single m0 read, response two cycles after accept.
        m0_req = mk_req(1'b1, 32'h100, 4'h0);
        #1;
        check_val("t1_m0_ready", m0_resp[0], 1'b1);
        check_val("t1_s_avalid", s_req[68], 1'b1);
        check_val("t1_s_addr", s_req[67:36], 32'h100);
        check_val("t1_m1_ready", m1_resp[0], 1'b0);
        tick();
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        #1;
        check_val("t1_cnt_1", dut.r_rd_cnt, 3'd1);
        check_val("t1_m0_rvalid_c1", m0_resp[1], 1'b0);
        tick();
        s_resp = mk_rsp(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check_val("t1_m0_rvalid_c2", m0_resp[1], 1'b1);
        check_val("t1_m0_rdata", m0_resp[33:2], 32'hDEAD_BEEF);
        check_val("t1_m1_rvalid", m1_resp[1], 1'b0);
        tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t1_cnt_0", dut.r_rd_cnt, 3'd0);

        // Contention with owner=0: m1 wins under either policy.
        m0_req = mk_req(1'b1, 32'h200, 4'h0);
        m1_req = mk_req(1'b1, 32'h300, 4'h0);
        s_resp = mk_rsp(1'b0, 1'b0, 32'h0);
        #1;
        check_val("t2_addr_owner0", s_req[67:36], 32'h300);
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t2_m1_ready", m1_resp[0], 1'b1);
        check_val("t2_m0_ready", m0_resp[0], 1'b0);
        tick();
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        m1_req = mk_req(1'b0, 32'h0, 4'h0);
        s_resp = mk_rsp(1'b0, 1'b1, 32'hCAFE_F00D);
        #1;
        check_val("t2_m1_rvalid", m1_resp[1], 1'b1);
        check_val("t2_m0_rvalid", m0_resp[1], 1'b0);
        tick();
        // Contention again with owner=1.
        m0_req = mk_req(1'b1, 32'h200, 4'h0);
        m1_req = mk_req(1'b1, 32'h300, 4'h0);
        s_resp = mk_rsp(1'b0, 1'b0, 32'h0);
`ifdef IOB_ARB_ROUND_ROBIN_EN
        exp_addr = 32'h200;
`else
        exp_addr = 32'h300;
`endif
        #1;
        check_val("t2_addr_owner1", s_req[67:36], exp_addr);
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        m1_req = mk_req(1'b0, 32'h0, 4'h0);
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        tick();

        // Fill to MAX_RD, then one response frees a slot.
        for (int i = 0; i < 4; i++) begin
            m0_req = mk_req(1'b1, 32'h400 + 32'(4 * i), 4'h0);
            #1;
            check_val($sformatf("t3_ready_%0d", i), m0_resp[0], 1'b1);
            tick();
        end
        m0_req = mk_req(1'b1, 32'h410, 4'h0);
        #1;
        check_val("t3_cnt_full", dut.r_rd_cnt, 3'd4);
        check_val("t3_stall_ready", m0_resp[0], 1'b0);
        check_val("t3_stall_avalid", s_req[68], 1'b0);
        s_resp = mk_rsp(1'b1, 1'b1, 32'h1111_0000);
        #1;
        check_val("t3_rvalid", m0_resp[1], 1'b1);
        tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t3_cnt_3", dut.r_rd_cnt, 3'd3);
        check_val("t3_resume_ready", m0_resp[0], 1'b1);
        tick();
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        s_resp = mk_rsp(1'b1, 1'b1, 32'h2222_0000);
        repeat (4) tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t3_drained", dut.r_rd_cnt, 3'd0);

        // m1 write blocked behind two m0 reads.
        m0_req = mk_req(1'b1, 32'h700, 4'h0);
        tick();
        tick();
        m0_req = mk_req(1'b0, 32'h0, 4'h0);
        m1_req = mk_req(1'b1, 32'h500, 4'hF);
        #1;
        check_val("t4_cnt_2", dut.r_rd_cnt, 3'd2);
        check_val("t4_m1_ready_a", m1_resp[0], 1'b0);
        check_val("t4_s_avalid_a", s_req[68], 1'b0);
        tick();
        s_resp = mk_rsp(1'b1, 1'b1, 32'h3333_0000);
        #1;
        check_val("t4_m1_ready_b", m1_resp[0], 1'b0);
        tick();
        #1;
        check_val("t4_m1_ready_c", m1_resp[0], 1'b0);
        check_val("t4_m0_rvalid_c", m0_resp[1], 1'b1);
        tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t4_m1_ready_d", m1_resp[0], 1'b1);
        check_val("t4_s_wstrb", s_req[3:0], 4'hF);
        check_val("t4_s_addr", s_req[67:36], 32'h500);
        tick();
        m1_req = mk_req(1'b0, 32'h0, 4'h0);
        #1;
        check_val("t4_cnt_after_wr", dut.r_rd_cnt, 3'd0);
        check_val("t4_owner", dut.r_owner, 1'b1);

        // Accept and response in the same cycle at rd_cnt=1.
        m1_req = mk_req(1'b1, 32'h600, 4'h0);
        tick();
        m1_req = mk_req(1'b1, 32'h604, 4'h0);
        s_resp = mk_rsp(1'b1, 1'b1, 32'h4444_0000);
        #1;
        check_val("t5_m1_rvalid", m1_resp[1], 1'b1);
        check_val("t5_m1_ready", m1_resp[0], 1'b1);
        tick();
        m1_req = mk_req(1'b0, 32'h0, 4'h0);
        #1;
        check_val("t5_cnt_same", dut.r_rd_cnt, 3'd1);
        check_val("t5_owner", dut.r_owner, 1'b1);
        tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t5_cnt_0", dut.r_rd_cnt, 3'd0);

        // Clock enable low freezes state even if a read is presented.
        cke    = 1'b0;
        m0_req = mk_req(1'b1, 32'h800, 4'h0);
        tick();
        check_val("t6_cke_cnt", dut.r_rd_cnt, 3'd0);
        check_val("t6_cke_owner", dut.r_owner, 1'b1);
        cke    = 1'b1;
        m0_req = mk_req(1'b0, 32'h0, 4'h0);

        // Unexpected rvalid: dropped, sticky error, cleared only by reset.
        s_resp = mk_rsp(1'b1, 1'b1, 32'h5555_0000);
        #1;
        check_val("t7_m0_rvalid", m0_resp[1], 1'b0);
        check_val("t7_m1_rvalid", m1_resp[1], 1'b0);
        tick();
        s_resp = mk_rsp(1'b1, 1'b0, 32'h0);
        #1;
        check_val("t7_err_set", err, 1'b1);
        tick();
        check_val("t7_err_sticky", err, 1'b1);
        arst = 1'b1;
        #1;
        check_val("t7_err_cleared", err, 1'b0);
        tick();
        arst = 1'b0;
        tick();
        check_val("t7_err_after_rst", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_bus_arbiter2.md
Name: iob_bus_arbiter2

Overview:
- Two-master, one-slave arbiter for the IOb native bus.
- Shares one memory port between the CPU instruction bus (m0) and the CPU data bus (m1).
- Sits between the CPU wrapper's ibus/dbus and a single-ported RAM or external-memory controller.
- Sequences grants, tracks outstanding reads, and routes read responses back to the issuing master.

Parameters:
- ADDR_W, 32, address width of all buses.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_RD, 4, max accepted-but-unanswered reads (1..15); counter width = $clog2(MAX_RD+1).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- cke_i  in  1  clock enable; all registers hold when low.
- m0_req_i  in  REQ_W  instruction master request; field order MSB→LSB {avalid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
- m0_resp_o  out  RESP_W  {rdata[DATA_W], rvalid, ready}; RESP_W = DATA_W+2.
- m1_req_i  in  REQ_W  data master request.
- m1_resp_o  out  RESP_W  data master response.
- s_req_o  out  REQ_W  merged request to the slave.
- s_resp_i  in  RESP_W  slave response.
- err_o  out  1  sticky; set by an unexpected slave rvalid.

Behaviour:
- State registers: owner (1b, last granted master), rd_cnt (outstanding reads), err (sticky). Reset: owner=0, rd_cnt=0, err=0.
- Grant is combinational, zero latency:
  - If rd_cnt>0, gnt=owner; only the owner may issue, so no switch while reads are in flight.
  - Else, if exactly one master has avalid=1, gnt is that master.
  - Else, if both have avalid=1, gnt=1 (data priority; see Optional Feature).
  - Else, gnt=owner.
- s_req_o: addr/wdata/wstrb copied from the gnt master. s_avalid = gnt master's avalid & ~stall, where stall = (rd_cnt==MAX_RD).
- Granted master ready = s_ready & ~stall. Non-granted master ready = 0.
- A master must hold its request stable until it sees ready; this block does not register requests.
- Accept = s_avalid & s_ready.
  - Read: wstrb==0. Write: wstrb!=0.
  - On any accept, owner<=gnt.
- rd_cnt update:
  - +1 on read accept; -1 on s_rvalid while rd_cnt>0.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_RD; stall blocks the increment.
- Read response routing:
  - s_rdata is broadcast to both masters.
  - rvalid is asserted only toward owner, and only when rd_cnt>0.
- Slave rvalid with rd_cnt==0: dropped (no master sees rvalid), err<=1. err clears only on reset.
- Writes are complete on accept; there is no write tracking. The master generates its own write ack.
- A same-owner write while that owner's reads are outstanding is allowed. The other master stalls (ready=0) until rd_cnt==0.
- Same cycle as the final rvalid (rd_cnt 1→0): the switch is not yet allowed; the new grant evaluates next cycle. Result: one bubble on owner change.
- Reset mid-transaction: state returns to reset values immediately. Any in-flight slave response after reset sets err. The system must reset the slave together with this block.
- Outputs while reset is asserted: s_avalid=0, both ready=0, both rvalid=0, err_o=0.

Optional Feature:
- Macro IOB_ARB_ROUND_ROBIN_EN.
- Defined: on contention (both avalid, rd_cnt==0), gnt = ~owner. This alternates masters and prevents instruction-fetch starvation.
- Undefined: fixed priority, m1 wins every contention.
- All other behaviour is identical.

Decomposition:
- Shared include iob_arb_conf.vh holds the field-offset macros for req/resp (AVALID, ADDR, WDATA, WSTRB, RDATA, RVALID, READY) and the REQ_W/RESP_W formulas.
- One sub-module: iob_arb_gnt, the combinational grant logic (inputs: avalids, owner, rd_cnt_zero; output: gnt), with the ROUND_ROBIN macro confined to it.
- The counter/owner/err registers use the existing iob_reg.

Test Plan:
- m0 read addr 0x100; slave ready=1 then rvalid after 2 cycles with rdata 0xDEADBEEF → m0 sees ready at cycle 0 and rvalid+0xDEADBEEF at cycle 2; m1 rvalid stays 0; rd_cnt 0→1→0.
- Both masters request at rd_cnt=0 → m1 granted. With ROUND_ROBIN_EN and owner=1 → m0 granted.
- m0 issues 4 back-to-back reads, slave withholds rvalid (MAX_RD=4) → 5th read sees ready=0 and s_avalid=0. One rvalid → rd_cnt=3 and the next read is accepted.
- m1 write (wstrb 0xF) while m0 has 2 reads outstanding → m1 ready=0 until both rvalids return; m1 is accepted the cycle after rd_cnt reaches 0.
- Read accept and rvalid in the same cycle at rd_cnt=1 → rd_cnt stays 1, owner unchanged.
- Slave rvalid at rd_cnt=0 → no master rvalid, err_o=1 persists; arst_i pulse → err_o=0.
